// File: rtl/gray_counter_updn.sv
// gray_counter_updn
//   Parametrised up/down Gray-code counter with synchronous clear, preset and
//   parallel load. Exactly one bit of the Gray output changes per count step,
//   which makes the count safe to sample from another clock domain.
//
// Parameters
//   WIDTH      counter width in bits (2..16)
//   RESET_VAL  Gray-coded value loaded while clr is low
//
// Ports
//   clk   in   rising-edge clock
//   clr   in   synchronous active-low clear, loads RESET_VAL (highest priority)
//   prs   in   synchronous active-low preset, loads Gray(2^WIDTH-1) = 100..0
//   cten  in   count enable, one step per clock while high
//   dir   in   count direction, 1 = up, 0 = down
//   ld    in   synchronous load enable, loads din
//   din   in   Gray-coded load value
//   out   out  registered Gray-coded count
//   bin   out  binary equivalent of out (combinational decode)
//   tc    out  terminal count for the current direction, qualified by cten
//   wrap  out  registered one-cycle pulse while out holds the post-wrap value
module gray_counter_updn #(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             prs,
    input  logic             cten,
    input  logic             dir,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    // Gray code of the all-ones binary value: MSB set, all other bits clear.
    localparam logic [WIDTH-1:0] GRAY_MAX = {1'b1, {(WIDTH-1){1'b0}}};

    // Gray -> binary is a prefix XOR from the MSB downwards. Folding with
    // doubling shift distances builds that prefix in log2(WIDTH) XOR levels
    // instead of a WIDTH-deep ripple chain.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int unsigned s = 1; s < WIDTH; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] bin_cur;
    logic [WIDTH-1:0] bin_step;
    logic             at_term;

    assign bin_cur  = gray2bin(out_q);
    assign bin_step = dir ? (bin_cur + ONE) : (bin_cur - ONE);
    assign at_term  = dir ? (out_q == GRAY_MAX) : (out_q == '0);

    // Next state for the non-reset priorities; clr is applied in the
    // register block itself.
    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (!prs) begin
            out_d = GRAY_MAX;
        end else if (ld) begin
            out_d = din;
        end else if (cten) begin
            out_d  = bin2gray(bin_step);
            // Leaving the terminal value is by definition the wrap step.
            wrap_d = at_term;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            out_q  <= RESET_VAL;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign bin  = bin_cur;
    assign tc   = cten & at_term;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter_updn.sv
// tb_gray_counter_updn
//   Self-checking bench for gray_counter_updn (WIDTH=4, RESET_VAL=0).
//   A behavioural model tracks the count as a plain integer; the Gray value is
//   derived from it arithmetically and compared with the DUT on every cycle.
//   Directed sequences pin the model with literal expectations, then a long
//   randomized run exercises all priorities and directions.
module tb_gray_counter_updn;

    localparam int W   = 4;
    localparam int MAX = 15;
    localparam logic [W-1:0] RV = 4'b0000;

    logic         clk = 1'b0;
    logic         clr, prs, cten, dir, ld;
    logic [W-1:0] din;
    logic [W-1:0] out, bin;
    logic         tc, wrap;

    int checks = 0;
    int errors = 0;

    gray_counter_updn #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk  (clk),
        .clr  (clr),
        .prs  (prs),
        .cten (cten),
        .dir  (dir),
        .ld   (ld),
        .din  (din),
        .out  (out),
        .bin  (bin),
        .tc   (tc),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // Inverse Gray by exhaustive search: whichever binary value encodes to g.
    function automatic int bin_of(input int g);
        for (int b = 0; b <= MAX; b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    int m = 0;
    bit mw = 1'b0;
    bit m_valid = 1'b0;
    bit m_counted = 1'b0;

    always @(posedge clk) begin
        m_counted <= 1'b0;
        if (!clr) begin
            m       <= bin_of(int'(RV));
            mw      <= 1'b0;
            m_valid <= 1'b1;
        end else if (!prs) begin
            m  <= MAX;
            mw <= 1'b0;
        end else if (ld) begin
            m  <= bin_of(int'(din));
            mw <= 1'b0;
        end else if (cten) begin
            mw        <= dir ? (m == MAX) : (m == 0);
            m         <= dir ? (m + 1) % (MAX + 1) : (m + MAX) % (MAX + 1);
            m_counted <= 1'b1;
        end else begin
            mw <= 1'b0;
        end
    end

    // ---------------- compare process ----------------
    logic [W-1:0] last_out;
    bit have_last = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("out",  int'(out),  gray_of(m));
            chk("bin",  int'(bin),  m);
            chk("tc",   int'(tc),   int'(cten && (dir ? (m == MAX) : (m == 0))));
            chk("wrap", int'(wrap), int'(mw));
            if (m_counted && have_last)
                chk("hamming", $countones(out ^ last_out), 1);
            last_out  = out;
            have_last = 1'b1;
        end
    end

    // Advance one clock; inputs are driven and literals checked just after
    // the falling edge, well away from the sampling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [W-1:0] seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                               4'b0110, 4'b0111, 4'b0101, 4'b0100,
                               4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000};

    initial begin
        clr = 1'b0; prs = 1'b1; cten = 1'b1; dir = 1'b1; ld = 1'b0; din = '0;

        // 1. reset with cten high, then hold
        tick(); tick();
        clr = 1'b1; cten = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_out",  int'(out),  0);
            chk("rst_bin",  int'(bin),  0);
            chk("rst_tc",   int'(tc),   0);
            chk("rst_wrap", int'(wrap), 0);
        end

        // 2. up count through a full wrap
        cten = 1'b1; dir = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("up_out", int'(out), int'(seq[k % 16]));
            chk("up_bin", int'(bin), k % 16);
            chk("up_tc",   int'(tc),   (k == 15) ? 1 : 0);
            chk("up_wrap", int'(wrap), (k == 16) ? 1 : 0);
        end

        // 3. down count from 0000
        dir = 1'b0;
        #1 chk("dn_tc0", int'(tc), 1);
        tick();
        chk("dn_out1",  int'(out),  4'b1000);
        chk("dn_bin1",  int'(bin),  15);
        chk("dn_wrap1", int'(wrap), 1);
        tick();
        chk("dn_out2",  int'(out),  4'b1001);
        chk("dn_bin2",  int'(bin),  14);
        chk("dn_wrap2", int'(wrap), 0);

        // 4. load wins over count, then count resumes from it
        ld = 1'b1; din = 4'b1100; cten = 1'b1; dir = 1'b1;
        tick();
        chk("ld_out", int'(out), 4'b1100);
        chk("ld_bin", int'(bin), 8);
        ld = 1'b0;
        tick();
        chk("ld_next_out", int'(out), 4'b1101);
        chk("ld_next_bin", int'(bin), 9);

        // 5. priority
        prs = 1'b0;
        tick();
        chk("prs_out", int'(out), 4'b1000);
        chk("prs_bin", int'(bin), 15);
        prs = 1'b1;
        clr = 1'b0; prs = 1'b0; ld = 1'b1; din = 4'b1111; cten = 1'b1;
        tick();
        chk("pri_out",  int'(out),  0);
        chk("pri_wrap", int'(wrap), 0);
        clr = 1'b1; prs = 1'b1; ld = 1'b0; dir = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_pre", int'(out), 4'b0110);
        clr = 1'b0;
        tick();
        chk("mid_clr", int'(out), 0);
        clr = 1'b1;

        // 6. hold at 0101, then direction change at 1000
        for (int k = 0; k < 6; k++) tick();
        chk("hold_pre", int'(out), 4'b0101);
        cten = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("hold_out", int'(out), 4'b0101);
            chk("hold_tc",  int'(tc),  0);
        end
        cten = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        chk("dirchg_at", int'(out), 4'b1000);
        chk("dirchg_tc_up", int'(tc), 1);
        dir = 1'b0;
        #1 chk("dirchg_tc_dn", int'(tc), 0);
        tick();
        chk("dirchg_out", int'(out), 4'b1001);
        chk("dirchg_bin", int'(bin), 14);

        // randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            clr  = ($urandom_range(99) >= 3);
            prs  = ($urandom_range(99) >= 3);
            ld   = ($urandom_range(99) < 6);
            cten = ($urandom_range(99) < 75);
            dir  = ($urandom_range(99) < 60);
            din  = W'($urandom_range(MAX));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
